// File: rtl/i2c_reg_slave.sv
// I2C target that turns bus write/read transactions into a register-file
// interface: a one-cycle write strobe plus an auto-incrementing register pointer.
module i2c_reg_slave #(
  parameter logic [6:0] I2C_ADDR    = 7'h70,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  // Pad synchronizers plus one previous-sample flop; all preset to the idle-bus level
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its source, independent of statement order.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl_rise   =  scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s &  scl_prev;
  assign start_cond =  scl_s &  scl_prev &  sda_prev & ~sda_s;
  assign stop_cond  =  scl_s &  scl_prev & ~sda_prev &  sda_s;

  state_t     state, state_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] shift, shift_d;
  logic [7:0] ptr, ptr_d;
  logic [7:0] wr_addr_d, wr_data_d;
  logic [7:0] byte_in;
  logic       sda_oe_d, busy_d, wr_en_d;
  logic       rw, rw_d;
  // phase: in write-ACK states, 1 once ACK is driven; in RDATA_ACK, 1 once the controller bit is sampled
  logic       phase, phase_d;

  assign byte_in = {shift[6:0], sda_s};

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    ptr_d     = ptr;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    rw_d      = rw;
    phase_d   = phase;

    if (wr_en) ptr_d = ptr + 8'd1;

    if (start_cond) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else if (stop_cond) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_in[7:1] == I2C_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
                phase_d = 1'b0;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        ADDR_ACK, SUB_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (state == ADDR_ACK && rw) begin
                // First read byte goes out on the same fall that ends the ACK
                shift_d  = rd_data;
                sda_oe_d = ~rd_data[7];
                state_d  = RDATA;
              end else if (state == ADDR_ACK) begin
                state_d = SUB;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end

        SUB: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_d   = byte_in;
              state_d = SUB_ACK;
              phase_d = 1'b0;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr;
              wr_data_d = byte_in;
              state_d   = WDATA_ACK;
              phase_d   = 1'b0;
            end
          end
        end

        RDATA: begin
          if (scl_fall) begin
            shift_d  = {shift[6:0], 1'b0};
            sda_oe_d = ~shift[6];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_d = RDATA_ACK;
              phase_d = 1'b0;
            end
          end
        end

        RDATA_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_d = 1'b0;
            end else begin
              shift_d   = rd_data;
              sda_oe_d  = ~rd_data[7];
              bit_cnt_d = 3'd0;
              state_d   = RDATA;
            end
          end else if (scl_rise) begin
            if (!sda_s) begin
              ptr_d   = ptr + 8'd1;
              phase_d = 1'b1;
            end else begin
              // Controller NACK: stay addressed (busy) but ignore the bus until STOP/START
              sda_oe_d = 1'b0;
              state_d  = IDLE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
      ptr     <= 8'd0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
      rw      <= 1'b0;
      phase   <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
      ptr     <= ptr_d;
      sda_oe  <= sda_oe_d;
      busy    <= busy_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      rw      <= rw_d;
      phase   <= phase_d;
    end
  end

  assign rd_addr = ptr;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: an open-drain bus model drives SCL/SDA and
// results are compared against hand-computed values with immediate assertions.
module tb_i2c_reg_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data;
  logic [7:0] mem [256];
  logic       sda_line;

  int total = 0;
  int bad   = 0;

  logic [15:0] wr_log [$];
  int          oe_cnt   = 0;
  int          busy_cnt = 0;

  assign sda_line = sda_m & ~sda_oe;
  assign rd_data  = mem[rd_addr];

  i2c_reg_slave #(.I2C_ADDR(7'h70), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) wr_log.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Quarter SCL period = 10 clk, so SCL runs at 1/40 of clk
  task automatic wait_q();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b;    wait_q();
    scl   = 1'b1; wait_q();
    s = sda_line; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(nack, s);
  endtask

  task automatic expect_wr(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
    logic [15:0] got;
    got = 16'hxxxx;
    if (idx < wr_log.size()) got = wr_log[idx];
    check(tag, {16'd0, got}, {16'd0, a, d});
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic       s;
    int         wr_base, oe_base, busy_base;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h05] = 8'hA5;
    mem[8'h06] = 8'h3C;

    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sda_oe",  {31'd0, sda_oe}, 32'd0);
    check("rst_busy",    {31'd0, busy},   32'd0);
    check("rst_wr_en",   {31'd0, wr_en},  32'd0);
    check("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
    wait_q();

    // Test 1: basic write with auto-increment
    wr_base = wr_log.size();
    i2c_start();
    write_byte(8'hE0, ack); check("t1_ack_addr", {31'd0, ack}, 32'd1);
    write_byte(8'h0A, ack); check("t1_ack_sub",  {31'd0, ack}, 32'd1);
    write_byte(8'h55, ack); check("t1_ack_d0",   {31'd0, ack}, 32'd1);
    write_byte(8'h1F, ack); check("t1_ack_d1",   {31'd0, ack}, 32'd1);
    check("t1_busy_mid", {31'd0, busy}, 32'd1);
    i2c_stop();
    wait_q();
    check("t1_wr_cnt", wr_log.size() - wr_base, 32'd2);
    expect_wr("t1_wr0", wr_base,     8'h0A, 8'h55);
    expect_wr("t1_wr1", wr_base + 1, 8'h0B, 8'h1F);
    check("t1_rd_addr", {24'd0, rd_addr}, 32'h0C);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // Test 2: wrong address is ignored
    wr_base = wr_log.size(); oe_base = oe_cnt; busy_base = busy_cnt;
    i2c_start();
    write_byte(8'hE2, ack); check("t2_nack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h0A, ack);
    write_byte(8'h55, ack);
    i2c_stop();
    wait_q();
    check("t2_oe_never",   oe_cnt - oe_base, 32'd0);
    check("t2_no_wr",      wr_log.size() - wr_base, 32'd0);
    check("t2_busy_never", busy_cnt - busy_base, 32'd0);

    // Test 3: set pointer, repeated start, read two bytes
    wr_base = wr_log.size();
    i2c_start();
    write_byte(8'hE0, ack); check("t3_ack_addr", {31'd0, ack}, 32'd1);
    write_byte(8'h05, ack); check("t3_ack_sub",  {31'd0, ack}, 32'd1);
    i2c_start();
    write_byte(8'hE1, ack); check("t3_ack_raddr", {31'd0, ack}, 32'd1);
    read_byte(1'b0, rd);    check("t3_rd0", {24'd0, rd}, 32'hA5);
    read_byte(1'b1, rd);    check("t3_rd1", {24'd0, rd}, 32'h3C);
    check("t3_busy_after_nack", {31'd0, busy}, 32'd1);
    check("t3_oe_after_nack",   {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    wait_q();
    check("t3_rd_addr", {24'd0, rd_addr}, 32'h06);
    check("t3_no_wr", wr_log.size() - wr_base, 32'd0);

    // Test 4: pointer wraps 0xFF -> 0x00
    wr_base = wr_log.size();
    i2c_start();
    write_byte(8'hE0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack); check("t4_ack_d1", {31'd0, ack}, 32'd1);
    i2c_stop();
    wait_q();
    check("t4_wr_cnt", wr_log.size() - wr_base, 32'd2);
    expect_wr("t4_wr0", wr_base,     8'hFF, 8'h11);
    expect_wr("t4_wr1", wr_base + 1, 8'h00, 8'h22);
    check("t4_rd_addr", {24'd0, rd_addr}, 32'h01);

    // Test 5: STOP cuts a data byte short after 5 bits
    wr_base = wr_log.size();
    i2c_start();
    write_byte(8'hE0, ack);
    write_byte(8'h03, ack);
    for (int i = 0; i < 5; i++) send_bit(i[0], s);
    i2c_stop();
    wait_q();
    check("t5_abort_no_wr", wr_log.size() - wr_base, 32'd0);
    check("t5_abort_busy",  {31'd0, busy}, 32'd0);
    i2c_start();
    write_byte(8'hE0, ack);
    write_byte(8'h02, ack);
    write_byte(8'h77, ack); check("t5_ack_d0", {31'd0, ack}, 32'd1);
    i2c_stop();
    wait_q();
    check("t5_wr_cnt", wr_log.size() - wr_base, 32'd1);
    expect_wr("t5_wr0", wr_base, 8'h02, 8'h77);

    // Test 6: reset during the address ACK bit
    wr_base = wr_log.size();
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 6 || i == 5, s);
    check("t6_ack_driven", {31'd0, sda_oe}, 32'd1);
    check("t6_busy_pre",   {31'd0, busy},   32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("t6_rst_busy",   {31'd0, busy},   32'd0);
    send_bit(1'b1, s);
    i2c_stop();
    wait_q();
    i2c_start();
    write_byte(8'hE0, ack); check("t6_ack_addr", {31'd0, ack}, 32'd1);
    write_byte(8'h09, ack);
    write_byte(8'h44, ack); check("t6_ack_d0", {31'd0, ack}, 32'd1);
    i2c_stop();
    wait_q();
    check("t6_wr_cnt", wr_log.size() - wr_base, 32'd1);
    expect_wr("t6_wr0", wr_base, 8'h09, 8'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
